// File: rtl/vga_timing_if.sv
// vga_timing_if: raster outputs of vga_timing.
// The master drives them and the colour layer stages consume them.
interface vga_timing_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       enable;
    logic       hsync;
    logic       vsync;
    logic       pixel_tick;
    logic       frame_start;

    modport master (
        output hcount, vcount, enable, hsync, vsync, pixel_tick, frame_start
    );

    modport slave (
        input hcount, vcount, enable, hsync, vsync, pixel_tick, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster counters with registered, zero-skew decodes.
// Optional macro VGA_SYNC_ALIGN_EN delays hsync/vsync by one pixel to match registered colour layers.
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 1
) (
    input  logic         clock,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    if (H_TOTAL > 1024) begin : g_h_total_check
        $error("vga_timing: H_TOTAL %0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_timing: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
        $error("vga_timing: CLK_DIV %0d outside 1..16", CLK_DIV);
    end

    // Decodes are widened by one bit so a range ending at 1024 still compares correctly.
    function automatic logic enable_of(input logic [9:0] h, input logic [9:0] v);
        return ({1'b0, h} < H_VIS) && ({1'b0, v} < V_VIS);
    endfunction

    function automatic logic hsync_of(input logic [9:0] h);
        return !(({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END));
    endfunction

    function automatic logic vsync_of(input logic [9:0] v);
        return !(({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END));
    endfunction

    logic [3:0] div_r;
    logic       tick_s;
    logic [9:0] hcount_r;
    logic [9:0] vcount_r;
    logic [9:0] hcount_next_s;
    logic [9:0] vcount_next_s;
    logic       enable_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       pixel_tick_r;
    logic       frame_start_r;

    // Next raster position: advance on tick, wrap line then frame.
    always_comb begin
        tick_s        = (div_r == DIV_LAST);
        hcount_next_s = hcount_r;
        vcount_next_s = vcount_r;
        if (tick_s) begin
            if (hcount_r == H_LAST) begin
                hcount_next_s = 10'd0;
                if (vcount_r == V_LAST) begin
                    vcount_next_s = 10'd0;
                end else begin
                    vcount_next_s = vcount_r + 10'd1;
                end
            end else begin
                hcount_next_s = hcount_r + 10'd1;
            end
        end else begin
            hcount_next_s = hcount_r;
            vcount_next_s = vcount_r;
        end
    end

    // Counters and decodes share one register stage so they never skew.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r         <= 4'd0;
            hcount_r      <= H_LAST;
            vcount_r      <= V_LAST;
            enable_r      <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            pixel_tick_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= tick_s ? 4'd0 : div_r + 4'd1;
            hcount_r      <= hcount_next_s;
            vcount_r      <= vcount_next_s;
            enable_r      <= enable_of(hcount_next_s, vcount_next_s);
            hsync_r       <= hsync_of(hcount_next_s);
            vsync_r       <= vsync_of(vcount_next_s);
            pixel_tick_r  <= tick_s;
            frame_start_r <= tick_s && (hcount_next_s == 10'd0) && (vcount_next_s == 10'd0);
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_d_r;
    logic vsync_d_r;

    // Sync lags the counters by one pixel; the stage only moves on tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_d_r <= 1'b1;
            vsync_d_r <= 1'b1;
        end else if (tick_s) begin
            hsync_d_r <= hsync_r;
            vsync_d_r <= vsync_r;
        end else begin
            hsync_d_r <= hsync_d_r;
            vsync_d_r <= vsync_d_r;
        end
    end

    assign vga.hsync = hsync_d_r;
    assign vga.vsync = vsync_d_r;
`else
    assign vga.hsync = hsync_r;
    assign vga.vsync = vsync_r;
`endif

    assign vga.hcount      = hcount_r;
    assign vga.vcount      = vcount_r;
    assign vga.enable      = enable_r;
    assign vga.pixel_tick  = pixel_tick_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: table vectors, hand sequences and a cycle-by-cycle arithmetic raster model
// for three vga_timing instances (full 640x480 at CLK_DIV=1, reduced geometry at CLK_DIV=2 and 3).
module tb_vga_timing;
`ifdef VGA_SYNC_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 4;
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       en;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       fs;
    } exp_t;

    typedef struct {
        int   m;
        exp_t e;
    } vec_t;

    logic       clock = 1'b0;
    logic [2:0] rst;
    int         m [3];
    int         tests;
    int         fails;

    always #5 clock = ~clock;

    vga_timing_if if0 ();
    vga_timing_if if1 ();
    vga_timing_if if2 ();

    vga_timing u0 (.clock(clock), .reset(rst[0]), .vga(if0));
    vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                 .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                 .CLK_DIV(2)) u1 (.clock(clock), .reset(rst[1]), .vga(if1));
    vga_timing #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                 .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                 .CLK_DIV(3)) u2 (.clock(clock), .reset(rst[2]), .vga(if2));

    function automatic exp_t obs(input int sel);
        if (sel == 0)
            return {if0.hcount, if0.vcount, if0.enable, if0.hsync, if0.vsync, if0.pixel_tick, if0.frame_start};
        else if (sel == 1)
            return {if1.hcount, if1.vcount, if1.enable, if1.hsync, if1.vsync, if1.pixel_tick, if1.frame_start};
        else
            return {if2.hcount, if2.vcount, if2.enable, if2.hsync, if2.vsync, if2.pixel_tick, if2.frame_start};
    endfunction

    // Expected outputs after mc clock edges with reset low: position is the linear pixel
    // index (frame_len-1 + ticks) mod frame_len, ticks = mc / cd.
    function automatic exp_t model(input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input int cd, input int mc);
        int   ht, vt, n, t, l, p, ph, pv;
        exp_t e;
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        n    = ht * vt;
        t    = mc / cd;
        l    = (n - 1 + t) % n;
        e.h  = 10'(l % ht);
        e.v  = 10'(l / ht);
        e.en = ((l % ht) < hv) && ((l / ht) < vv);
        e.pt = (mc > 0) && ((mc % cd) == 0);
        e.fs = e.pt && (l == 0);
        if (ALIGN) p = (t == 0) ? -1 : (n - 2 + t) % n;
        else       p = l;
        if (p < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            ph   = p % ht;
            pv   = p / ht;
            e.hs = !((ph >= hv + hf) && (ph < hv + hf + hsw));
            e.vs = !((pv >= vv + vf) && (pv < vv + vf + vsw));
        end
        return e;
    endfunction

    function automatic exp_t model_of(input int sel, input int mc);
        if (sel == 0) return model(640, 16, 96, 48, 480, 10, 2, 33, 1, mc);
        else if (sel == 1) return model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 2, mc);
        else return model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 3, mc);
    endfunction

    function automatic vec_t mk(input int mc, input int h, input int v, input logic en,
                                input logic hs, input logic vs, input logic pt, input logic fs);
        vec_t r;
        r.m = mc;
        r.e = {10'(h), 10'(v), en, hs, vs, pt, fs};
        return r;
    endfunction

    task automatic chk(input string name, input exp_t a, input exp_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got h=%0d v=%0d en=%0b hs=%0b vs=%0b pt=%0b fs=%0b, expected h=%0d v=%0d en=%0b hs=%0b vs=%0b pt=%0b fs=%0b",
                     name, a.h, a.v, a.en, a.hs, a.vs, a.pt, a.fs, e.h, e.v, e.en, e.hs, e.vs, e.pt, e.fs);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, a, e);
        end
    endtask

    // One clock: track edges since reset release, then compare every instance at the falling edge.
    task automatic cycle();
        @(posedge clock);
        for (int k = 0; k < 3; k++) m[k] = rst[k] ? 0 : m[k] + 1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) chk($sformatf("model_u%0d", k), obs(k), model_of(k, m[k]));
    endtask

    task automatic frame_check(input int sel, input int cd);
        int   n, vs_lo, pt_n;
        exp_t o;
        n = 0;
        do begin
            cycle();
            n++;
            o = obs(sel);
        end while (!o.fs && n < 4000);
        chk_int($sformatf("frame_wait_u%0d", sel), int'(o.fs), 1);
        n = 0; vs_lo = 0; pt_n = 0;
        do begin
            cycle();
            n++;
            o = obs(sel);
            if (!o.vs) vs_lo++;
            if (o.pt) pt_n++;
        end while (!o.fs && n < 4000);
        chk_int($sformatf("frame_period_u%0d", sel), n, SHT * SVT * cd);
        chk_int($sformatf("vsync_low_u%0d", sel), vs_lo, SVS * SHT * cd);
        chk_int($sformatf("ticks_per_frame_u%0d", sel), pt_n, SHT * SVT);
    endtask

    initial begin
        vec_t vec [13];
        int   hs_lo, en_hi, v_start;
        int   rcnt [3];

        tests = 0;
        fails = 0;
        rst   = 3'b111;
        for (int k = 0; k < 3; k++) begin
            m[k]    = 0;
            rcnt[k] = 0;
        end

        vec[0]  = mk(0,    799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        vec[1]  = mk(1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vec[2]  = mk(2,    1,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[3]  = mk(640,  639, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[4]  = mk(641,  640, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[5]  = mk(657,  656, 0,   1'b0, ALIGN ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
        vec[6]  = mk(658,  657, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vec[7]  = mk(752,  751, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vec[8]  = mk(753,  752, 0,   1'b0, ALIGN ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
        vec[9]  = mk(754,  753, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[10] = mk(800,  799, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[11] = mk(801,  0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vec[12] = mk(1281, 480, 1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset held five cycles, then the table walks the first lines of u0.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("reset_hold", obs(0), vec[0].e);
        end
        rst = 3'b000;
        for (int i = 1; i < 13; i++) begin
            while (m[0] < vec[i].m) cycle();
            chk($sformatf("vec%0d", i), obs(0), vec[i].e);
        end

        // One full line of u0: sync width, visible width, line increment.
        hs_lo   = 0;
        en_hi   = 0;
        v_start = int'(if0.vcount);
        for (int i = 0; i < 800; i++) begin
            cycle();
            if (!if0.hsync) hs_lo++;
            if (if0.enable) en_hi++;
        end
        chk_int("line_hsync_low", hs_lo, 96);
        chk_int("line_enable_high", en_hi, 640);
        chk_int("line_vcount_inc", int'(if0.vcount), v_start + 1);

        frame_check(1, 2);
        frame_check(2, 3);

        // Mid-frame reset on u2 with its divider at 1.
        while (m[2] % 3 != 1) cycle();
        rst[2] = 1'b1;
        cycle();
        chk("midreset_hold", obs(2), {10'(SHT - 1), 10'(SVT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        rst[2] = 1'b0;
        cycle();
        chk("midreset_rel1", obs(2), {10'(SHT - 1), 10'(SVT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        cycle();
        chk("midreset_rel2", obs(2), {10'(SHT - 1), 10'(SVT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        cycle();
        chk("midreset_rel3", obs(2), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // Free run with sporadic random resets; the model check inside cycle() does the work.
        for (int c = 0; c < 15000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (rcnt[k] > 0) begin
                    rcnt[k]--;
                    if (rcnt[k] == 0) rst[k] = 1'b0;
                end else if ($urandom_range(799, 0) == 0) begin
                    rst[k]  = 1'b1;
                    rcnt[k] = int'($urandom_range(4, 1));
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
